// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and configuration legality.
package adder_pkg;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

    function automatic bit legal_config(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for the pipelined adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, sum, co
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, sum, co
    );
endinterface

// File: rtl/pipelined_adder_add_stage.sv
// One CHUNK-wide slice of the adder with its pipeline register (valid, partial sum, carry).
module add_stage #(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_in,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic             valid_q,
    output logic [CHUNK-1:0] s_q,
    output logic             c_q
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
        end else if (en) begin
            valid_q <= valid_in;
            s_q     <= total[CHUNK-1:0];
            c_q     <= total[CHUNK];
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: the carry ripples through one CHUNK per clock,
// with a single global stall so bubbles and results move in lockstep.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!legal_config(WIDTH, STAGES)) begin : g_bad_config
        $error("pipelined_adder: need WIDTH >= 1, STAGES >= 1 and STAGES dividing WIDTH");
    end

    logic          en;
    logic [STAGES:0] valid;
    logic [STAGES:0] carry;

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;
    assign valid[0]     = bus.in_valid && en;
    assign carry[0]     = bus.ci;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] a_chunk;
        logic [CHUNK-1:0] b_chunk;
        logic [CHUNK-1:0] s_chunk;

        // Operand chunk k waits k cycles so it meets the carry coming out of stage k-1.
        if (k == 0) begin : g_operand_direct
            assign a_chunk = bus.a[CHUNK-1:0];
            assign b_chunk = bus.b[CHUNK-1:0];
        end else begin : g_operand_delay
            logic [CHUNK-1:0] a_dly [k];
            logic [CHUNK-1:0] b_dly [k];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < k; i++) begin
                        a_dly[i] <= '0;
                        b_dly[i] <= '0;
                    end
                end else if (en) begin
                    a_dly[0] <= bus.a[k*CHUNK +: CHUNK];
                    b_dly[0] <= bus.b[k*CHUNK +: CHUNK];
                    for (int i = 1; i < k; i++) begin
                        a_dly[i] <= a_dly[i-1];
                        b_dly[i] <= b_dly[i-1];
                    end
                end
            end

            assign a_chunk = a_dly[k-1];
            assign b_chunk = b_dly[k-1];
        end

        add_stage #(
            .CHUNK (CHUNK)
        ) u_add_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .valid_in (valid[k]),
            .a        (a_chunk),
            .b        (b_chunk),
            .c_in     (carry[k]),
            .valid_q  (valid[k+1]),
            .s_q      (s_chunk),
            .c_q      (carry[k+1])
        );

        // Finished sum chunk k rides along until the last stage reaches the output.
        if (k == STAGES - 1) begin : g_sum_direct
            assign bus.sum[k*CHUNK +: CHUNK] = s_chunk;
        end else begin : g_sum_delay
            localparam int DEPTH = STAGES - 1 - k;
            logic [CHUNK-1:0] s_dly [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        s_dly[i] <= '0;
                    end
                end else if (en) begin
                    s_dly[0] <= s_chunk;
                    for (int i = 1; i < DEPTH; i++) begin
                        s_dly[i] <= s_dly[i-1];
                    end
                end
            end

            assign bus.sum[k*CHUNK +: CHUNK] = s_dly[DEPTH-1];
        end
    end

    assign bus.out_valid = valid[STAGES];
    assign bus.co        = carry[STAGES];

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined WIDTH-bit adder with carry-in and carry-out. Operands are split into STAGES equal chunks, and the carry ripples through one chunk per clock. A valid/ready handshake on both sides supports back-to-back streaming and output backpressure. It generalises the team's 1-bit RTL adder for datapaths where a full-width ripple carry cannot close timing in one cycle.

## Interface
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- STAGES, 2, pipeline depth; must divide WIDTH evenly. CHUNK = WIDTH/STAGES.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands a, b, ci are valid this cycle.
- in_ready  output  1  the adder accepts operands this cycle.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- ci  input  1  carry-in.
- out_valid  output  1  sum and co hold a valid result.
- out_ready  input  1  the downstream block accepts the result this cycle.
- sum  output  WIDTH  (a + b + ci) mod 2^WIDTH.
- co  output  1  carry out of bit WIDTH-1.

## Operation
- Accept occurs when in_valid && in_ready. Deliver occurs when out_valid && out_ready.
- Global stall enable: en = !out_valid || out_ready. in_ready = en, combinational, with no dependence on in_valid.
- Every pipeline register updates only when en = 1. When en = 0, all registers hold, including sum, co and out_valid.
- Stage k (0..STAGES-1) computes chunk k: {c_k+1, s_k} = a[k] + b[k] + c_k.
  - c_0 = ci at stage 0.
  - For k > 0, c_k is the carry registered out of stage k-1.
- Each stage's register holds:
  - the valid bit;
  - sum chunks 0..k, which are already final;
  - operand chunks k+1..STAGES-1 for A and B, still pending;
  - the carry out of chunk k.
- The last stage register drives sum, co and out_valid directly, with no combinational path from the inputs.
- Arithmetic is unsigned with a CHUNK+1-bit add per stage. sum wraps modulo 2^WIDTH. co = 1 exactly when a + b + ci ≥ 2^WIDTH.
- Bubbles: when en = 1 and no accept occurs, a stage-0 valid bit of 0 enters the pipe. Bubbles propagate and do not collapse, because the stall is global.
- STAGES = 1: the design degenerates to a single registered full-width adder with the same handshake.

## Timing
- Reset values (rst_n = 0 at a clock edge): all stage valid bits 0, out_valid 0, sum 0, co 0, internal carries 0. Operand and partial-sum registers are also cleared to 0.
- Reset mid-operation: all in-flight results are discarded. No result from before reset ever appears on out_valid.
- After rst_n returns high, the first accept is allowed on the first cycle, since in_ready = 1 once out_valid = 0.
- Latency: an operand accepted at edge n appears with out_valid = 1 after edge n+STAGES-1. It is visible in the cycle following that edge, provided no stall cycles intervene. Each stall cycle adds exactly one cycle.
- Throughput: one result per cycle while out_ready = 1.
- Backpressure: when out_valid = 1 and out_ready = 0, sum and co are stable and in_ready = 0 in the same cycle.
- Simultaneous deliver and accept in one cycle is legal and keeps full throughput.
- out_valid, sum and co change only on clock edges where en = 1 or rst_n = 0.

## Structure
- Shared package adder_pkg holds a function chunk_width(WIDTH, STAGES).
- Width/depth legality is checked by an elaboration-time assertion: STAGES ≥ 1 and WIDTH % STAGES == 0.
- One sub-module is natural: add_stage, one CHUNK-wide adder plus its pipeline register, with an en input.
  - The top instantiates STAGES copies through a generate loop.
  - The top holds the handshake logic and operand/sum shift wiring.

## Test plan
- WIDTH=8, STAGES=2, a=0xFF, b=0x01, ci=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0x00, co=1.
- Carry across chunk boundary: a=0x0F, b=0x01, ci=0 -> sum=0x10, co=0. Also a=0x7F, b=0x7F, ci=1 -> sum=0xFF, co=0.
- Stream of 16 back-to-back random operands, out_ready=1 -> 16 consecutive results, in order, matching a reference model, one per cycle.
- Hold out_ready=0 for 5 cycles with a result pending -> sum/co stable, in_ready=0, no loss or duplication; results resume in order after release.
- Assert rst_n=0 for 1 cycle with 2 results in flight -> out_valid=0, sum=0, co=0 next cycle; neither pre-reset result ever appears.
- WIDTH=4, STAGES=1 and WIDTH=16, STAGES=4: exhaustive (4-bit) and random (16-bit) sweeps -> latency of 1 and 4 cycles respectively, all sums correct.
